shift_right_pipe: RTL and testbench
===================================

// Module: shift_right_pipe
//
// PURPOSE
// - Lane-granular right shifter, the counterpart of the combinational
//   left shifter in the same datapath.
// - Takes a 96-bit word of 8 x 12-bit lanes and shifts it right by 0..5 lanes.
//   Vacated top lanes are loaded with a 12-bit fill value.
// - Two-stage registered pipeline with valid/ready handshakes on both sides.
//   Sits between the unpack stage and the lane aligner.
//
// PARAMETERS
// - LANE_W     12  bits per lane
// - LANES      8   lanes per word; data width = LANE_W*LANES
// - SHIFT_W    3   width of the shift amount
// - MAX_SHIFT  5   largest legal shift; amounts above it are errors
//
// PORTS
// - clk        in   1        clock; all logic is on the rising edge
// - rst_n      in   1        synchronous, active-low reset
// - in_valid   in   1        input beat present
// - in_ready   out  1        block can accept an input beat
// - in         in   96       input word; lane k = in[12k+11:12k]
// - shift      in   3        right shift amount, in lanes
// - fill       in   12       value loaded into vacated lanes
// - out_valid  out  1        output beat present
// - out_ready  in   1        downstream accepts the output beat
// - out        out  96       shifted word
// - out_err    out  1        this beat had shift > MAX_SHIFT
//
// BEHAVIOUR
// - Transfer rule: a beat moves on a port when valid && ready on the same edge.
// - Stage 1 (S1) registers in, shift and fill, and sets the illegal flag (shift>MAX_SHIFT).
// - Stage 2 (S2) registers the shifted result and out_err.
// - Output is combinational from S2. Latency is 2 cycles from input accept to out_valid.
// - Shift function for s = shift:
//   - out lane i = in lane (i+s) when i+s < LANES
//   - out lane i = fill otherwise
//   - s=0 passes the word through unchanged.
// - Illegal shift (6 or 7): all 8 lanes = fill and out_err=1. The beat is still
//   delivered; it is never dropped.
// - Stage advance:
//   - S2 loads when !S2.valid || out_ready.
//   - S1 loads when !S1.valid || S2 loads.
//   - in_ready = !S1.valid || S2 loads. This gives full throughput of 1 beat per cycle.
// - Backpressure:
//   - While out_ready=0 and both stages are valid, in_ready=0.
//   - out, out_err and out_valid hold stable until the beat is accepted.
// - Simultaneous events:
//   - Accepting into S1 while S1 hands to S2 in the same cycle: no bubble, no loss.
//   - out_ready=1 with S2 empty: no effect.
// - Reset, including mid-operation:
//   - Both valid bits clear, so out_valid=0, in_ready=1 in the first cycle after reset.
//   - out=0, out_err=0.
//   - In-flight beats are discarded.
// - Data registers need no reset; the output regs are reset so out is 0.
//
// CONFIGURATION
// - Macro SHIFT_RIGHT_PIPE_STICKY_EN.
// - When defined:
//   - Extra port out_sticky (out, 1) = OR of every input bit shifted off the bottom,
//     i.e. in lanes 0..s-1.
//   - It is 1 for any nonzero discarded bit and 0 when s=0.
//   - On an illegal shift it is the OR of all 96 input bits.
//   - It is registered alongside out, has the same latency, and resets to 0.
// - When undefined: the port and its logic are absent; everything else is identical.
//
// TESTING
// - Lane k = k+1 (0x001..0x008), shift=2, fill=0xABC:
//   -> after 2 cycles, lanes 0..5 = 0x003..0x008, lanes 6..7 = 0xABC, out_err=0.
// - Same word, shift=0 -> out == in. Shift=5, fill=0 -> lanes 0..2 = 0x006..0x008, rest 0.
// - Shift=6, fill=0x5A5 -> all lanes 0x5A5, out_err=1. Then shift=1 -> out_err=0.
// - 10 back-to-back beats with out_ready=1 -> 10 outputs on consecutive cycles, in order.
// - out_ready=0 for 4 cycles with 3 beats offered:
//   -> in_ready drops after 2 accepted, out holds stable,
//   -> all 3 beats delivered in order after release.
// - rst_n=0 for one cycle with both stages full:
//   -> next cycle out_valid=0, in_ready=1, out=0.
// - With STICKY_EN: lane 1 = 0x001, all else 0:
//   -> shift=2 gives out_sticky=1; shift=1 gives out_sticky=0.

Source files
------------

// File: rtl/shift_right_pipe_if.sv
// Handshake bundle for shift_right_pipe.
// master = upstream producer / downstream consumer side (drives in_*, out_ready).
// slave  = the shifter itself.
// Macro SHIFT_RIGHT_PIPE_STICKY_EN adds the out_sticky signal.
interface shift_right_pipe_if #(
  parameter int LANE_W  = 12,
  parameter int LANES   = 8,
  parameter int SHIFT_W = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANE_W*LANES-1:0]   in;
  logic [SHIFT_W-1:0]        shift;
  logic [LANE_W-1:0]         fill;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANE_W*LANES-1:0]   out;
  logic                      out_err;
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
  logic                      out_sticky;
`endif

`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
  modport master (output in_valid, in, shift, fill, out_ready,
                  input  in_ready, out_valid, out, out_err, out_sticky);
  modport slave  (input  in_valid, in, shift, fill, out_ready,
                  output in_ready, out_valid, out, out_err, out_sticky);
`else
  modport master (output in_valid, in, shift, fill, out_ready,
                  input  in_ready, out_valid, out, out_err);
  modport slave  (input  in_valid, in, shift, fill, out_ready,
                  output in_ready, out_valid, out, out_err);
`endif
endinterface

// File: rtl/shift_right_pipe.sv
// Lane-granular right shifter: 8 x 12-bit lanes shifted right by 0..5 lanes,
// vacated top lanes loaded with a fill value. Two registered stages with
// valid/ready on both sides; full throughput, latency 2 cycles.
// Shift amounts above MAX_SHIFT produce an all-fill word flagged by out_err.
// Optional macro SHIFT_RIGHT_PIPE_STICKY_EN adds out_sticky: OR of every
// input bit shifted off the bottom.
module shift_right_pipe #(
  parameter int LANE_W    = 12,
  parameter int LANES     = 8,
  parameter int SHIFT_W   = 3,
  parameter int MAX_SHIFT = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_right_pipe_if.slave  bus
);
  localparam int DATA_W = LANE_W * LANES;
  localparam logic [SHIFT_W-1:0] MAX_SHIFT_V = SHIFT_W'(MAX_SHIFT);

  // Shift the word right by s lanes, pulling fill lanes in from the top.
  function automatic logic [DATA_W-1:0] lane_shift(
    input logic [DATA_W-1:0]  d,
    input logic [SHIFT_W-1:0] s,
    input logic [LANE_W-1:0]  f,
    input logic               ill
  );
    logic [2*DATA_W-1:0] ext;
    ext = {{LANES{f}}, d} >> (LANE_W * int'(s));
    if (ill) return {LANES{f}};
    return ext[DATA_W-1:0];
  endfunction

`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
  // OR of the lanes that fall off the bottom (all lanes on an illegal shift).
  function automatic logic lane_sticky(
    input logic [DATA_W-1:0]  d,
    input logic [SHIFT_W-1:0] s,
    input logic               ill
  );
    logic [DATA_W-1:0] mask;
    mask = ~({DATA_W{1'b1}} << (LANE_W * int'(s)));
    if (ill) return |d;
    return |(d & mask);
  endfunction
`endif

  logic                s1_vld_q;
  logic [DATA_W-1:0]   s1_data_q;
  logic [SHIFT_W-1:0]  s1_shift_q;
  logic [LANE_W-1:0]   s1_fill_q;
  logic                s1_ill_q;
  logic                s1_ill_d;

  logic                s2_vld_q;
  logic [DATA_W-1:0]   s2_data_q;
  logic [DATA_W-1:0]   s2_data_d;
  logic                s2_err_q;
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
  logic                s2_sticky_q;
  logic                s2_sticky_d;
`endif

  logic                s2_load;
  logic                s1_load;
  logic                in_fire;

  assign s2_load      = !s2_vld_q || bus.out_ready;
  assign s1_load      = !s1_vld_q || s2_load;
  assign in_fire      = bus.in_valid && s1_load;
  assign bus.in_ready = s1_load;

  // Illegal-shift flag is decided on the way into S1.
  always_comb begin
    s1_ill_d = (bus.shift > MAX_SHIFT_V);
  end

  // S1 valid: refills whenever the stage is free or hands its beat onward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
    end else if (s1_load) begin
      s1_vld_q <= bus.in_valid;
    end
  end

  // S1 payload captured on an accepted input beat; no reset needed.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_data_q  <= bus.in;
      s1_shift_q <= bus.shift;
      s1_fill_q  <= bus.fill;
      s1_ill_q   <= s1_ill_d;
    end
  end

  // ---- S1 -> S2 boundary: shift result computed from S1 registers ----
  always_comb begin
    s2_data_d = lane_shift(s1_data_q, s1_shift_q, s1_fill_q, s1_ill_q);
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
    s2_sticky_d = lane_sticky(s1_data_q, s1_shift_q, s1_ill_q);
`endif
  end

  // S2 output registers; reset so the output word reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld_q    <= 1'b0;
      s2_data_q   <= '0;
      s2_err_q    <= 1'b0;
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
      s2_sticky_q <= 1'b0;
`endif
    end else if (s2_load) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_data_q   <= s2_data_d;
        s2_err_q    <= s1_ill_q;
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
        s2_sticky_q <= s2_sticky_d;
`endif
      end
    end
  end

  assign bus.out_valid  = s2_vld_q;
  assign bus.out        = s2_data_q;
  assign bus.out_err    = s2_err_q;
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
  assign bus.out_sticky = s2_sticky_q;
`endif

endmodule

// File: tb/tb_shift_right_pipe.sv
// Bench for shift_right_pipe: directed vectors, throughput, backpressure,
// reset mid-flight and randomized traffic checked against a lane-level model.
module tb_shift_right_pipe;
  typedef struct {
    logic [95:0] data;
    logic        err;
    logic        sticky;
  } res_t;

  typedef struct {
    logic [95:0] got;
    logic [95:0] exp;
    logic        gerr;
    logic        eerr;
    logic        gst;
    logic        est;
    bit          unexp;
  } pair_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  res_t  exp_q[$];
  pair_t pairs[$];

  shift_right_pipe_if bus ();

  shift_right_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: built lane by lane from the shifting rules.
  function automatic res_t model(input logic [95:0] w, input int s, input logic [11:0] f);
    res_t r;
    logic [11:0] lane;
    r.data   = '0;
    r.err    = (s > 5);
    r.sticky = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s > 5 || i + s >= 8) lane = f;
      else                     lane = w[(i + s) * 12 +: 12];
      r.data[i * 12 +: 12] = lane;
    end
    for (int k = 0; k < 8; k++) begin
      if ((s > 5 || k < s) && (w[k * 12 +: 12] != 12'd0)) r.sticky = 1'b1;
    end
    return r;
  endfunction

  // Transfer monitor: pairs each delivered beat with the model's expectation.
  always @(posedge clk) begin
    pair_t p;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        p.got  = bus.out;
        p.gerr = bus.out_err;
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
        p.gst  = bus.out_sticky;
`else
        p.gst  = 1'b0;
`endif
        if (exp_q.size() == 0) begin
          p.unexp = 1'b1;
          p.exp = '0; p.eerr = 1'b0; p.est = 1'b0;
        end else begin
          res_t e;
          e = exp_q.pop_front();
          p.unexp = 1'b0;
          p.exp = e.data; p.eerr = e.err; p.est = e.sticky;
        end
        pairs.push_back(p);
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in, int'(bus.shift), bus.fill));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [95:0] w, input logic [2:0] s, input logic [11:0] f);
    bus.in_valid = 1'b1;
    bus.in       = w;
    bus.shift    = s;
    bus.fill     = f;
  endtask

  task automatic send(input logic [95:0] w, input logic [2:0] s, input logic [11:0] f);
    int n;
    n = 0;
    drive(w, s, f);
    #1;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_accept", {95'd0, bus.in_ready}, 96'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_pairs(input int n);
    int k;
    k = 0;
    while (pairs.size() < n && k < 50) begin
      step();
      k++;
    end
    chk("drain_count", 96'(pairs.size()), 96'(n));
  endtask

  task automatic check_pairs();
    pair_t p;
    while (pairs.size() != 0) begin
      p = pairs.pop_front();
      chk("unexpected_out", {95'd0, p.unexp}, 96'd0);
      chk("out_data", p.got, p.exp);
      chk("out_err", {95'd0, p.gerr}, {95'd0, p.eerr});
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
      chk("out_sticky", {95'd0, p.gst}, {95'd0, p.est});
`endif
    end
  endtask

  task automatic directed(input string tag, input logic [95:0] w, input logic [2:0] s,
                          input logic [11:0] f, input logic [95:0] expw,
                          input logic experr, input logic expst);
    send(w, s, f);
    chk({tag, "_lat1_valid"}, {95'd0, bus.out_valid}, 96'd0);
    step();
    chk({tag, "_valid"}, {95'd0, bus.out_valid}, 96'd1);
    chk({tag, "_out"}, bus.out, expw);
    chk({tag, "_err"}, {95'd0, bus.out_err}, {95'd0, experr});
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
    chk({tag, "_sticky"}, {95'd0, bus.out_sticky}, {95'd0, expst});
`else
    if (expst === 1'bx) $display("note: sticky unknown");
`endif
    wait_pairs(1);
    check_pairs();
  endtask

  initial begin
    logic [95:0] w;
    logic [95:0] b[3];
    logic [2:0]  bs[3];
    logic [11:0] bf[3];
    res_t        r0;
    logic        acc;
    int          n_acc;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in = '0;
    bus.shift = '0;
    bus.fill = '0;
    bus.out_ready = 1'b1;

    // Power-on reset.
    step();
    step();
    chk("rst_out_valid", {95'd0, bus.out_valid}, 96'd0);
    chk("rst_in_ready", {95'd0, bus.in_ready}, 96'd1);
    chk("rst_out", bus.out, 96'd0);
    chk("rst_out_err", {95'd0, bus.out_err}, 96'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors.
    w = 96'h008_007_006_005_004_003_002_001;
    directed("shift2", w, 3'd2, 12'hABC, 96'hABC_ABC_008_007_006_005_004_003, 1'b0, 1'b1);
    directed("shift0", w, 3'd0, 12'hFFF, w, 1'b0, 1'b0);
    directed("shift5", w, 3'd5, 12'h000, 96'h000_000_000_000_000_008_007_006, 1'b0, 1'b1);
    directed("shift6", w, 3'd6, 12'h5A5, {8{12'h5A5}}, 1'b1, 1'b1);
    directed("shift1", w, 3'd1, 12'h000, 96'h000_008_007_006_005_004_003_002, 1'b0, 1'b1);
    directed("shift7", w, 3'd7, 12'h123, {8{12'h123}}, 1'b1, 1'b1);
    directed("stk_s2", 96'h001_000, 3'd2, 12'h000, 96'd0, 1'b0, 1'b1);
    directed("stk_s1", 96'h001_000, 3'd1, 12'h000, 96'h001, 1'b0, 1'b0);

    // Ten back-to-back beats at full throughput.
    for (int i = 0; i < 10; i++) begin
      drive({$urandom, $urandom, $urandom}, 3'($urandom_range(7)), 12'($urandom));
      #1;
      chk("b2b_in_ready", {95'd0, bus.in_ready}, 96'd1);
      if (i >= 2) chk("b2b_out_valid", {95'd0, bus.out_valid}, 96'd1);
      step();
    end
    chk("b2b_out_valid_9", {95'd0, bus.out_valid}, 96'd1);
    bus.in_valid = 1'b0;
    step();
    chk("b2b_out_valid_10", {95'd0, bus.out_valid}, 96'd1);
    step();
    chk("b2b_idle", {95'd0, bus.out_valid}, 96'd0);
    chk("b2b_count", 96'(pairs.size()), 96'd10);
    check_pairs();

    // Backpressure: two beats fill the pipe, the third waits.
    for (int i = 0; i < 3; i++) begin
      b[i]  = {$urandom, $urandom, $urandom};
      bs[i] = 3'($urandom_range(5));
      bf[i] = 12'($urandom);
    end
    r0 = model(b[0], int'(bs[0]), bf[0]);
    bus.out_ready = 1'b0;
    drive(b[0], bs[0], bf[0]);
    #1;
    chk("bp_acc0", {95'd0, bus.in_ready}, 96'd1);
    step();
    drive(b[1], bs[1], bf[1]);
    #1;
    chk("bp_acc1", {95'd0, bus.in_ready}, 96'd1);
    step();
    drive(b[2], bs[2], bf[2]);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_in_ready_low", {95'd0, bus.in_ready}, 96'd0);
      chk("bp_hold_valid", {95'd0, bus.out_valid}, 96'd1);
      chk("bp_hold_out", bus.out, r0.data);
      chk("bp_hold_err", {95'd0, bus.out_err}, {95'd0, r0.err});
      step();
    end
    chk("bp_no_early_out", 96'(pairs.size()), 96'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_acc2", {95'd0, bus.in_ready}, 96'd1);
    step();
    bus.in_valid = 1'b0;
    wait_pairs(3);
    check_pairs();

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    drive({$urandom, $urandom, $urandom}, 3'd3, 12'h111);
    step();
    drive({$urandom, $urandom, $urandom}, 3'd4, 12'h222);
    step();
    bus.in_valid = 1'b0;
    chk("mid_full_valid", {95'd0, bus.out_valid}, 96'd1);
    chk("mid_full_ready", {95'd0, bus.in_ready}, 96'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", {95'd0, bus.out_valid}, 96'd0);
    chk("mid_rst_in_ready", {95'd0, bus.in_ready}, 96'd1);
    chk("mid_rst_out", bus.out, 96'd0);
    chk("mid_rst_err", {95'd0, bus.out_err}, 96'd0);
`ifdef SHIFT_RIGHT_PIPE_STICKY_EN
    chk("mid_rst_sticky", {95'd0, bus.out_sticky}, 96'd0);
`endif
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    chk("mid_rst_discard", 96'(pairs.size()), 96'd0);

    // Randomized traffic with random backpressure.
    n_acc = 0;
    for (int c = 0; c < 600; c++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      if (!bus.in_valid && $urandom_range(3) != 0)
        drive({$urandom, $urandom, $urandom}, 3'($urandom_range(7)), 12'($urandom));
      #1;
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        bus.in_valid = 1'b0;
        n_acc++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_pairs(n_acc);
    check_pairs();
    chk("rand_exp_empty", 96'(exp_q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
